// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning, debouncing front end for a 4x4 matrix keypad.
// Drives one column at a time, synchronizes the pulled-down rows, debounces
// press and release, and emits a single-cycle key_valid pulse per accepted key.
// Optional feature: define KEYPAD_DEBUG_EN to expose a registered "inside a
// debounce window" flag on debug; otherwise debug is tied to 0.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       held,
  output logic       debug
);

  localparam int SW = (SETTLE_CYCLES   > 1) ? $clog2(SETTLE_CYCLES)   : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] S_TC = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_CYCLES - 1);

  // Key map indexed by {row, col}; row3 col0 is '*' (E), row3 col2 is '#' (F).
  localparam logic [15:0][3:0] KMAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t          state;
  logic [1:0]      col, row;
  logic [SW-1:0]   scnt;
  logic [DW-1:0]   dcnt;
  logic [3:0]      sync1, rs;
  logic [3:0]      row_oh;
  logic            hit;
  logic [1:0]      hit_row;
  logic            match;

  // Two-flop synchronizer on the asynchronous row inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      rs    <= '0;
    end else begin
      sync1 <= rows;
      rs    <= sync1;
    end
  end

  // Decode the synchronized rows: exactly one bit set is a usable press.
  always_comb begin
    hit     = 1'b0;
    hit_row = 2'd0;
    case (rs)
      4'b0001: begin hit = 1'b1; hit_row = 2'd0; end
      4'b0010: begin hit = 1'b1; hit_row = 2'd1; end
      4'b0100: begin hit = 1'b1; hit_row = 2'd2; end
      4'b1000: begin hit = 1'b1; hit_row = 2'd3; end
      default: begin hit = 1'b0; hit_row = 2'd0; end
    endcase
    row_oh = 4'b0001 << row;
    match  = (rs == row_oh);
  end

  // Scan / debounce FSM; column, key and status outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      cols      <= 4'b0001;
      row       <= 2'd0;
      scnt      <= '0;
      dcnt      <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      held      <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scnt == S_TC) begin
            scnt <= '0;
            if (hit) begin
              row   <= hit_row;
              dcnt  <= '0;
              state <= PRESS_DB;
            end else begin
              col  <= col + 2'd1;
              cols <= {cols[2:0], cols[3]};
            end
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        PRESS_DB: begin
          if (match) begin
            if (dcnt == D_TC) begin
              key       <= KMAP[{row, col}];
              key_valid <= 1'b1;
              state     <= HELD;
            end else begin
              dcnt <= dcnt + DW'(1);
            end
          end else begin
            col   <= col + 2'd1;
            cols  <= {cols[2:0], cols[3]};
            state <= SCAN;
          end
        end
        HELD: begin
          held <= 1'b1;
          if (!rs[row]) begin
            dcnt  <= '0;
            state <= REL_DB;
          end
        end
        REL_DB: begin
          if (rs[row]) begin
            state <= HELD;
          end else if (dcnt == D_TC) begin
            held  <= 1'b0;
            col   <= col + 2'd1;
            cols  <= {cols[2:0], cols[3]};
            state <= SCAN;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

`ifdef KEYPAD_DEBUG_EN
  logic dbg;

  // Flag is 1 exactly while the FSM sits in PRESS_DB or REL_DB.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg <= 1'b0;
    end else begin
      case (state)
        SCAN:     dbg <= (scnt == S_TC) && hit;
        PRESS_DB: dbg <= match && (dcnt != D_TC);
        HELD:     dbg <= !rs[row];
        REL_DB:   dbg <= !rs[row] && (dcnt != D_TC);
        default:  dbg <= 1'b0;
      endcase
    end
  end

  assign debug = dbg;
`else
  assign debug = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SETTLE_CYCLES=4,
// DEBOUNCE_CYCLES=16. The keypad is a behavioural switch matrix: a row reads 1
// when a pressed key sits in the currently driven column.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       held;
  logic       debug;

  logic [3:0][3:0] pk;   // pk[row][col] = key pressed
  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [3:0] last_key = 4'h0;

  keypad_scanner #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key(key), .key_valid(key_valid), .held(held), .debug(debug)
  );

  always #5 clk = ~clk;

  // Switch matrix with pulldowns.
  always_comb begin
    for (int r = 0; r < 4; r++) rows[r] = |(pk[r] & cols);
  end

  // Pulse monitor, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      pulses++;
      last_key = key;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int n0, input string tag);
    int i = 0;
    while (pulses <= n0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(pulses > n0), 1);
  endtask

  task automatic wait_cols(input logic [3:0] v, input string tag);
    int i = 0;
    while (cols !== v && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk(tag, cols, v);
  endtask

  task automatic bounce(input int r, input int c, input bit start);
    bit v = start;
    for (int p = 0; p < 5; p++) begin
      pk[r][c] = v;
      repeat (3) @(negedge clk);
      v = ~v;
    end
  endtask

  initial begin
    int n0;
    logic [3:0] e;
    pk    = '0;
    reset = 1'b1;

    // Reset values and idle column scan.
    repeat (5) @(negedge clk);
    chk("rst_cols", cols, 4'b0001);
    chk("rst_key", key, 4'h0);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_held", held, 1'b0);
    chk("rst_debug", debug, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = 4'b0001 << (((i + 1) / 4) % 4);
      chk("scan_cols", cols, e);
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_key", key, 4'h0);

    // Press [1][2] and hold.
    n0 = pulses;
    pk[1][2] = 1'b1;
    wait_pulse(n0, "k6_pulse");
    chk("k6_key", last_key, 4'h6);
    repeat (200) @(negedge clk);
    chk("k6_once", pulses, n0 + 1);
    chk("k6_cols", cols, 4'b0100);
    chk("k6_held", held, 1'b1);
    pk = '0;
    repeat (18) @(negedge clk);
    chk("k6_held_rel", held, 1'b1);
`ifdef KEYPAD_DEBUG_EN
    chk("reldb_debug", debug, 1'b1);
`endif
    @(negedge clk);
    chk("k6_held_drop", held, 1'b0);

    // Press [2][1]; key holds the previous value until then.
    repeat (20) @(negedge clk);
    chk("k6_hold_key", key, 4'h6);
    n0 = pulses;
    pk[2][1] = 1'b1;
    wait_pulse(n0, "k8_pulse");
    chk("k8_key", key, 4'h8);
    pk = '0;
    repeat (60) @(negedge clk);
    chk("k8_released", held, 1'b0);

    // Bounced press and bounced release of [1][2].
    n0 = pulses;
    bounce(1, 2, 1'b1);
    pk[1][2] = 1'b1;
    wait_pulse(n0, "bnc_pulse");
    repeat (60) @(negedge clk);
    chk("bnc_once", pulses, n0 + 1);
    chk("bnc_key", key, 4'h6);
    bounce(1, 2, 1'b0);
    pk[1][2] = 1'b0;
    repeat (60) @(negedge clk);
    chk("bnc_rel_none", pulses, n0 + 1);
    chk("bnc_rel_held", held, 1'b0);

    // Hold [0][0], then [3][3] while held: second key only after release.
    n0 = pulses;
    pk[0][0] = 1'b1;
    wait_pulse(n0, "k1_pulse");
    chk("k1_key", key, 4'h1);
    pk[3][3] = 1'b1;
    repeat (100) @(negedge clk);
    chk("k1_no_second", pulses, n0 + 1);
    chk("k1_cols", cols, 4'b0001);
    pk[0][0] = 1'b0;
    wait_pulse(n0 + 1, "kd_pulse");
    chk("kd_key", key, 4'hD);
    pk = '0;
    repeat (60) @(negedge clk);

    // Reset during press debounce of [3][1].
    wait_cols(4'b0001, "k0_col0");
    pk[3][1] = 1'b1;
    wait_cols(4'b0010, "k0_col1");
    n0 = pulses;
    repeat (6) @(negedge clk);
`ifdef KEYPAD_DEBUG_EN
    chk("pdb_debug", debug, 1'b1);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("mid_cols", cols, 4'b0001);
    chk("mid_key", key, 4'h0);
    chk("mid_kv", key_valid, 1'b0);
    chk("mid_held", held, 1'b0);
    chk("mid_debug", debug, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_nopulse", pulses, n0);
    wait_pulse(n0, "k0_pulse");
    chk("k0_key", last_key, 4'h0);
    chk("k0_once", pulses, n0 + 1);
    pk = '0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
